// File: rtl/pixel_pkg.sv
// pixel_pkg: shared color codes, color type and clear-engine state encoding.
package pixel_pkg;
  localparam int PIX_COLOR_W = 3;
  typedef logic [PIX_COLOR_W-1:0] color_t;
  localparam color_t ERASE      = 3'b000;
  localparam color_t RED        = 3'b001;
  localparam color_t GREEN      = 3'b010;
  localparam color_t BLUE       = 3'b011;
  localparam color_t YELLOW     = 3'b100;
  localparam color_t PURPLE     = 3'b101;
  localparam color_t GRID_COLOR = PURPLE;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} fb_state_t;
endpackage

// File: rtl/pixel_framebuffer_if.sv
// pixel_framebuffer_if: brush write, clear control and video read signals of the framebuffer.
interface pixel_framebuffer_if #(
  parameter int COORD_W = 7,
  parameter int COLOR_W = 3
);
  logic               wr_en;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               clear_req;
  logic               busy;
  logic               clear_done;
  logic               rd_valid;
  logic [9:0]         rd_x;
  logic [9:0]         rd_y;
  logic [COLOR_W-1:0] color_out;
  logic               color_valid;
  modport master (
    output wr_en, wr_x, wr_y, wr_color, clear_req, rd_valid, rd_x, rd_y,
    input  busy, clear_done, color_out, color_valid
  );
  modport slave (
    input  wr_en, wr_x, wr_y, wr_color, clear_req, rd_valid, rd_x, rd_y,
    output busy, clear_done, color_out, color_valid
  );
endinterface

// File: rtl/pixel_framebuffer_canvas_ram.sv
// canvas_ram: simple dual-port synchronous RAM, read returns old data on a same-address write.
module canvas_ram #(
  parameter int AW = 14,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/pixel_framebuffer.sv
// pixel_framebuffer: scaled/offset canvas framebuffer with full-canvas clear engine.
// Optional grid overlay on readout: define PIXEL_FRAMEBUFFER_GRID_OVERLAY_EN.
module pixel_framebuffer
  import pixel_pkg::*;
#(
  parameter int                 COORD_W      = 7,
  parameter int                 COLOR_W      = 3,
  parameter int                 SCALE_SHIFT  = 1,
  parameter int                 X_OFFSET     = 64,
  parameter int                 Y_OFFSET     = 48,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = 3'b101,
  parameter int                 GRID_SPACING = 50
) (
  input logic clk,
  input logic reset,
  pixel_framebuffer_if.slave fb
);
  localparam int AW = 2 * COORD_W;
  fb_state_t state_q, state_d;
  logic [AW-1:0] clear_addr_q, clear_addr_d;
  logic inside_q, inside_d, vld_q, color_valid_q;
  logic [COLOR_W-1:0] color_out_q, color_out_d, ram_q, wdata;
  logic [10:0] dx, dy;
  logic [9:0] sx, sy;
  logic [AW-1:0] raddr, waddr;
  logic we;
`ifdef PIXEL_FRAMEBUFFER_GRID_OVERLAY_EN
  logic [AW-1:0] addr_q;
  logic grid;
`endif
  always_comb begin
    dx = 11'({1'b0, fb.rd_x}) - 11'(X_OFFSET);
    dy = 11'({1'b0, fb.rd_y}) - 11'(Y_OFFSET);
    sx = dx[9:0] >> SCALE_SHIFT;
    sy = dy[9:0] >> SCALE_SHIFT;
    inside_d = !dx[10] && !dy[10] && (sx >> COORD_W) == '0 && (sy >> COORD_W) == '0;
    raddr = {sy[COORD_W-1:0], sx[COORD_W-1:0]};
  end
  always_comb begin
    state_d = state_q;
    clear_addr_d = clear_addr_q;
    unique case (state_q)
      IDLE: if (fb.clear_req) begin
        state_d = CLEAR;
        clear_addr_d = '0;
      end
      CLEAR: begin
        clear_addr_d = clear_addr_q + 1'b1;
        if (&clear_addr_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // The clear engine owns the write port; brush writes land only in IDLE.
  always_comb begin
    we = state_q == CLEAR || (state_q == IDLE && fb.wr_en);
    waddr = state_q == CLEAR ? clear_addr_q : {fb.wr_y, fb.wr_x};
    wdata = state_q == CLEAR ? COLOR_W'(ERASE) : fb.wr_color;
  end
`ifdef PIXEL_FRAMEBUFFER_GRID_OVERLAY_EN
  always_comb begin
    grid = (int'(addr_q[COORD_W-1:0]) % GRID_SPACING) == 0 || (int'(addr_q[AW-1:COORD_W]) % GRID_SPACING) == 0;
    color_out_d = !inside_q ? BORDER_COLOR : grid ? COLOR_W'(GRID_COLOR) : ram_q;
  end
  always_ff @(posedge clk) addr_q <= raddr;
`else
  always_comb color_out_d = inside_q ? ram_q : BORDER_COLOR;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      clear_addr_q <= '0;
      inside_q <= 1'b0;
      vld_q <= 1'b0;
      color_out_q <= COLOR_W'(ERASE);
      color_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_addr_q <= clear_addr_d;
      inside_q <= inside_d;
      vld_q <= fb.rd_valid;
      color_out_q <= color_out_d;
      color_valid_q <= vld_q;
    end
  end
  canvas_ram #(.AW(AW), .DW(COLOR_W)) u_ram (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(ram_q)
  );
  assign fb.busy = state_q == CLEAR;
  assign fb.clear_done = state_q == DONE;
  assign fb.color_out = color_out_q;
  assign fb.color_valid = color_valid_q;
endmodule

// File: tb/tb_pixel_framebuffer.sv
// tb_pixel_framebuffer: directed and randomized checks against a canvas-array reference model.
module tb_pixel_framebuffer;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  logic [2:0] model [16384];
  logic [2:0] expq [$];
  int busy_cnt, done_cnt;
  logic [2:0] old;
  always #5 clk = ~clk;
  pixel_framebuffer_if fb ();
  pixel_framebuffer dut (.clk(clk), .reset(reset), .fb(fb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] expect_px(input int x, input int y);
    int dx, dy, cx, cy;
    dx = x - 64;
    dy = y - 48;
    if (dx < 0 || dy < 0 || dx / 2 >= 128 || dy / 2 >= 128) return 3'b101;
    cx = dx / 2;
    cy = dy / 2;
`ifdef PIXEL_FRAMEBUFFER_GRID_OVERLAY_EN
    if (cx % 50 == 0 || cy % 50 == 0) return 3'b101;
`endif
    return model[cy * 128 + cx];
  endfunction

  function automatic int scr_x(input int cx); return 64 + 2 * cx; endfunction
  function automatic int scr_y(input int cy); return 48 + 2 * cy; endfunction

  task automatic wr(input int x, input int y, input logic [2:0] c);
    fb.wr_en = 1'b1;
    fb.wr_x = 7'(x);
    fb.wr_y = 7'(y);
    fb.wr_color = c;
    tick();
    fb.wr_en = 1'b0;
    model[y * 128 + x] = c;
  endtask

  task automatic rd(input string tag, input int x, input int y);
    fb.rd_valid = 1'b1;
    fb.rd_x = 10'(x);
    fb.rd_y = 10'(y);
    tick();
    fb.rd_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(fb.color_valid), 32'd1);
    chk(tag, 32'(fb.color_out), 32'(expect_px(x, y)));
  endtask

  task automatic rand_stream(input string tag, input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      x = ($urandom_range(0, 1) == 1) ? $urandom_range(60, 323) : $urandom_range(0, 639);
      y = ($urandom_range(0, 1) == 1) ? $urandom_range(44, 307) : $urandom_range(0, 479);
      expq.push_back(expect_px(x, y));
      fb.rd_valid = 1'b1;
      fb.rd_x = 10'(x);
      fb.rd_y = 10'(y);
      tick();
      if (i > 0) chk(tag, 32'(fb.color_out), 32'(expq.pop_front()));
    end
    fb.rd_valid = 1'b0;
    tick();
    chk(tag, 32'(fb.color_out), 32'(expq.pop_front()));
  endtask

  initial begin
    reset = 1'b1;
    fb.wr_en = 1'b0; fb.wr_x = '0; fb.wr_y = '0; fb.wr_color = '0;
    fb.clear_req = 1'b0; fb.rd_valid = 1'b0; fb.rd_x = '0; fb.rd_y = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(fb.busy), 32'd0);
    chk("rst_done", 32'(fb.clear_done), 32'd0);
    chk("rst_cvalid", 32'(fb.color_valid), 32'd0);
    chk("rst_color", 32'(fb.color_out), 32'd0);
    reset = 1'b0;
    fb.rd_valid = 1'b1; fb.rd_x = 10'd10; fb.rd_y = 10'd10;
    tick();
    fb.rd_valid = 1'b0;
    chk("lat1_valid", 32'(fb.color_valid), 32'd0);
    tick();
    chk("lat2_valid", 32'(fb.color_valid), 32'd1);
    chk("border", 32'(fb.color_out), 32'd5);
    tick();
    chk("lat3_valid", 32'(fb.color_valid), 32'd0);
    fb.clear_req = 1'b1;
    tick();
    fb.clear_req = 1'b0;
    repeat (16400) tick();
    for (int a = 0; a < 16384; a++) model[a] = 3'b000;
    wr(5, 7, 3'b010);
    rd("wr_a", 74, 62);
    rd("wr_b", 75, 63);
    rd("wr_prior", 76, 62);
    wr(20, 20, 3'b011);
    old = expect_px(scr_x(20), scr_y(20));
    fb.wr_en = 1'b1; fb.wr_x = 7'd20; fb.wr_y = 7'd20; fb.wr_color = 3'b110;
    fb.rd_valid = 1'b1; fb.rd_x = 10'(scr_x(20)); fb.rd_y = 10'(scr_y(20));
    tick();
    fb.wr_en = 1'b0; fb.rd_valid = 1'b0;
    model[20 * 128 + 20] = 3'b110;
    tick();
    chk("rdw_old", 32'(fb.color_out), 32'(old));
    rd("rdw_new", scr_x(20), scr_y(20));
    for (int i = 0; i < 200; i++) wr($urandom_range(0, 127), $urandom_range(0, 127), 3'($urandom_range(0, 7)));
    rand_stream("rand1", 300);
    wr(0, 0, 3'b001);
    wr(127, 127, 3'b100);
    wr(64, 64, 3'b011);
    rd("fill_far", scr_x(127), scr_y(127));
    fb.clear_req = 1'b1;
    tick();
    fb.clear_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 16400; i++) begin
      if (fb.busy) busy_cnt++;
      if (fb.clear_done) done_cnt++;
      fb.wr_en = (i == 500);
      fb.clear_req = (i == 500 || i == 16000);
      fb.wr_x = 7'd3; fb.wr_y = 7'd3; fb.wr_color = 3'b001;
      tick();
    end
    fb.wr_en = 1'b0;
    fb.clear_req = 1'b0;
    for (int a = 0; a < 16384; a++) model[a] = 3'b000;
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd16384);
    chk("clr_done_pulses", 32'(done_cnt), 32'd1);
    rd("clr_00", scr_x(0), scr_y(0));
    rd("clr_127", scr_x(127), scr_y(127));
    rd("clr_64", scr_x(64), scr_y(64));
    rd("clr_brush", scr_x(3), scr_y(3));
    wr(0, 125, 3'b011);
    wr(1, 0, 3'b111);
    fb.wr_en = 1'b1; fb.wr_x = 7'd10; fb.wr_y = 7'd0; fb.wr_color = 3'b110;
    fb.clear_req = 1'b1;
    tick();
    fb.wr_en = 1'b0; fb.clear_req = 1'b0;
    model[10] = 3'b110;
    repeat (100) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(fb.busy), 32'd0);
    chk("mid_rst_done", 32'(fb.clear_done), 32'd0);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (fb.clear_done) done_cnt++;
      tick();
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    for (int a = 0; a <= 100; a++) model[a] = 3'b000;
    rd("mid_keep_16000", scr_x(0), scr_y(125));
    rd("mid_clr_10", scr_x(10), scr_y(0));
    rd("mid_clr_1", scr_x(1), scr_y(0));
    for (int i = 0; i < 100; i++) wr($urandom_range(0, 127), $urandom_range(1, 127), 3'($urandom_range(0, 7)));
    rand_stream("rand2", 200);
    wr(50, 3, 3'b010);
    wr(3, 50, 3'b010);
    wr(51, 3, 3'b010);
    rd("grid_x50", scr_x(50), scr_y(3));
    rd("grid_y50", scr_x(3), scr_y(50));
    rd("grid_x51", scr_x(51), scr_y(3));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
